// File: rtl/sh2_mac_unit_pkg.sv
// Shared MAC op codes, FSM state type, saturation limits and op classification helpers.
package sh2_mac_unit_pkg;

  localparam logic [3:0] MAC_OP_NOP    = 4'd0;
  localparam logic [3:0] MAC_OP_MULSW  = 4'd1;
  localparam logic [3:0] MAC_OP_MULUW  = 4'd2;
  localparam logic [3:0] MAC_OP_MULL   = 4'd3;
  localparam logic [3:0] MAC_OP_DMULSL = 4'd4;
  localparam logic [3:0] MAC_OP_DMULUL = 4'd5;
  localparam logic [3:0] MAC_OP_MACW   = 4'd6;
  localparam logic [3:0] MAC_OP_MACL   = 4'd7;
  localparam logic [3:0] MAC_OP_CLRMAC = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL1 = 2'd1,
    ST_MUL2 = 2'd2
  } mac_state_e;

  localparam logic [31:0] MACW_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] MACW_SAT_MIN = 32'h8000_0000;
  localparam logic [63:0] MACL_SAT_MAX = 64'h0000_7FFF_FFFF_FFFF;
  localparam logic [63:0] MACL_SAT_MIN = 64'hFFFF_8000_0000_0000;

  function automatic logic op_is_word(input logic [3:0] op);
    return (op == MAC_OP_MULSW) || (op == MAC_OP_MULUW) || (op == MAC_OP_MACW);
  endfunction

  function automatic logic op_is_long(input logic [3:0] op);
    return (op == MAC_OP_MULL) || (op == MAC_OP_DMULSL) ||
           (op == MAC_OP_DMULUL) || (op == MAC_OP_MACL);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return !((op == MAC_OP_MULUW) || (op == MAC_OP_DMULUL));
  endfunction

endpackage

// File: rtl/sh2_mac_unit_if.sv
// Control/data bundle between the EX stage (master) and the MAC unit (slave).
interface sh2_mac_unit_if;
  logic        ce;
  logic        start;
  logic [3:0]  op;
  logic        sat;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr;
  logic        wsel;
  logic [31:0] wd;
  logic        rsel;
  logic [31:0] rd;
  logic [31:0] mach;
  logic [31:0] macl;
  logic        busy;

  modport master (
    output ce, start, op, sat, a, b, wr, wsel, wd, rsel,
    input  rd, mach, macl, busy
  );

  modport slave (
    input  ce, start, op, sat, a, b, wr, wsel, wd, rsel,
    output rd, mach, macl, busy
  );
endinterface

// File: rtl/sh2_mac_mult.sv
// Combinational 33x17 signed multiplier shared by both multiply phases.
module sh2_mac_mult (
  input  logic signed [32:0] i_a,
  input  logic signed [16:0] i_b,
  output logic signed [49:0] o_p
);
  assign o_p = 50'(i_a) * 50'(i_b);
endmodule

// File: rtl/sh2_mac_unit.sv
// SH-2 MAC unit: owns MACH/MACL, runs word ops in one cycle and long ops in two
// on a shared 33x17 multiplier (low half of B first, then high half).
module sh2_mac_unit
  import sh2_mac_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MACH = 32'h0000_0000,
  parameter logic [31:0] RESET_MACL = 32'h0000_0000
) (
  input logic           i_clk,
  input logic           i_rst,
  sh2_mac_unit_if.slave io_mac
);
  localparam logic signed [64:0] LIM_HI = 65'($signed(MACL_SAT_MAX));
  localparam logic signed [64:0] LIM_LO = 65'($signed(MACL_SAT_MIN));

  mac_state_e         r_state, w_state_next;
  logic [3:0]         r_op;
  logic               r_sat;
  logic [31:0]        r_a, r_b, r_mach, r_macl;
  logic signed [49:0] r_p;

  logic               w_idle, w_issue_mul, w_issue_clr, w_write_ok;
  logic               w_signed, w_word, w_final;
  logic signed [32:0] w_mul_a;
  logic signed [16:0] w_mul_b;
  logic signed [49:0] w_mul_p;
  logic [31:0]        w_prod_w;
  logic [63:0]        w_prod_l, w_acc;
  logic [32:0]        w_sum_w;
  logic signed [64:0] w_sum_l;
  logic [31:0]        w_res_mach, w_res_macl;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_issue_mul = w_idle && io_mac.start && (op_is_word(io_mac.op) || op_is_long(io_mac.op));
  assign w_issue_clr = w_idle && io_mac.start && (io_mac.op == MAC_OP_CLRMAC);
  assign w_write_ok  = w_idle && io_mac.wr;
  assign w_signed    = op_is_signed(r_op);
  assign w_word      = op_is_word(r_op);
  assign w_final     = ((r_state == ST_MUL1) && w_word) || (r_state == ST_MUL2);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= ST_IDLE;
    else if (io_mac.ce)
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_issue_mul) w_state_next = ST_MUL1;
      ST_MUL1: w_state_next = w_word ? ST_IDLE : ST_MUL2;
      ST_MUL2: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Long ops: MUL1 uses B[15:0] as a positive 17-bit value, MUL2 the extended B[31:16].
  always_comb begin
    if (w_word)
      w_mul_a = {{17{w_signed & r_a[15]}}, r_a[15:0]};
    else
      w_mul_a = {w_signed & r_a[31], r_a};
    if (r_state == ST_MUL2)
      w_mul_b = {w_signed & r_b[31], r_b[31:16]};
    else if (w_word)
      w_mul_b = {w_signed & r_b[15], r_b[15:0]};
    else
      w_mul_b = {1'b0, r_b[15:0]};
  end

  sh2_mac_mult u_mult (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  assign w_prod_w = w_mul_p[31:0];
  assign w_prod_l = 64'({w_mul_p, 16'h0000}) + 64'(r_p);
  assign w_acc    = {r_mach, r_macl};
  assign w_sum_w  = {r_macl[31], r_macl} + {w_prod_w[31], w_prod_w};
  assign w_sum_l  = $signed({w_acc[63], w_acc}) + $signed({w_prod_l[63], w_prod_l});

  always_comb begin
    w_res_mach = r_mach;
    w_res_macl = r_macl;
    case (r_op)
      MAC_OP_MULSW, MAC_OP_MULUW: w_res_macl = w_prod_w;
      MAC_OP_MULL:                w_res_macl = w_prod_l[31:0];
      MAC_OP_DMULSL, MAC_OP_DMULUL: {w_res_mach, w_res_macl} = w_prod_l;
      MAC_OP_MACW: begin
        if (!r_sat)
          {w_res_mach, w_res_macl} = w_acc + 64'($signed(w_prod_w));
        else if (w_sum_w[32] != w_sum_w[31]) begin
          w_res_macl = w_sum_w[32] ? MACW_SAT_MIN : MACW_SAT_MAX;
          w_res_mach = {r_mach[31:1], 1'b1};
        end else
          w_res_macl = w_sum_w[31:0];
      end
      MAC_OP_MACL: begin
        if (r_sat && (w_sum_l > LIM_HI))
          {w_res_mach, w_res_macl} = MACL_SAT_MAX;
        else if (r_sat && (w_sum_l < LIM_LO))
          {w_res_mach, w_res_macl} = MACL_SAT_MIN;
        else
          {w_res_mach, w_res_macl} = w_sum_l[63:0];
      end
      default: ;
    endcase
  end

  // An LDS write and a START in the same cycle both land here, so the op accumulates onto the new value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mach <= RESET_MACH;
      r_macl <= RESET_MACL;
      r_op   <= MAC_OP_NOP;
      r_sat  <= 1'b0;
      r_a    <= 32'h0;
      r_b    <= 32'h0;
      r_p    <= '0;
    end else if (io_mac.ce) begin
      if (w_write_ok) begin
        if (io_mac.wsel) r_mach <= io_mac.wd;
        else             r_macl <= io_mac.wd;
      end
      if (w_issue_clr) begin
        r_mach <= 32'h0;
        r_macl <= 32'h0;
      end
      if (w_issue_mul) begin
        r_op  <= io_mac.op;
        r_sat <= io_mac.sat;
        r_a   <= io_mac.a;
        r_b   <= io_mac.b;
      end
      if ((r_state == ST_MUL1) && !w_word)
        r_p <= w_mul_p;
      if (w_final) begin
        r_mach <= w_res_mach;
        r_macl <= w_res_macl;
      end
    end
  end

  assign io_mac.busy = !w_idle;
  assign io_mac.rd   = io_mac.rsel ? r_mach : r_macl;
  assign io_mac.mach = r_mach;
  assign io_mac.macl = r_macl;

endmodule

// File: tb/tb_sh2_mac_unit.sv
// Self-checking bench for sh2_mac_unit: vector table plus hand-written hazard sequences.
module tb_sh2_mac_unit;
  import sh2_mac_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sh2_mac_unit_if mac_if ();

  sh2_mac_unit #(
    .RESET_MACH (32'h0000_0000),
    .RESET_MACL (32'h0000_0000)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_mac (mac_if)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        sat;
    logic [31:0] a, b, pre_h, pre_l, exp_h, exp_l;
    int          busy;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] h, l;
    int          busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    mac_if.wr = 1'b1; mac_if.wsel = 1'b1; mac_if.wd = h;
    @(negedge clk);
    mac_if.wsel = 1'b0; mac_if.wd = l;
    @(negedge clk);
    mac_if.wr = 1'b0;
  endtask

  // Called at a negedge; issues the op on the next posedge and tracks it to completion.
  task automatic run_op(input string name, input logic [3:0] op, input logic sat,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int ebusy,
                        input bit hold_junk, input int stall);
    exp_t        e, got;
    int          cnt, stall_left;
    logic [31:0] pre_l;
    e = '{name, eh, el, ebusy};
    pre_l = mac_if.macl;
    mac_if.start = 1'b1; mac_if.op = op; mac_if.sat = sat; mac_if.a = a; mac_if.b = b;
    sb_q.push_back(e);
    @(negedge clk);
    mac_if.start = 1'b0; mac_if.op = MAC_OP_NOP; mac_if.wr = 1'b0;
    mac_if.sat = ~sat; mac_if.a = $urandom; mac_if.b = $urandom;
    cnt = 0;
    stall_left = stall;
    while (mac_if.busy === 1'b1 && cnt < 20) begin
      cnt++;
      if (stall_left > 0) begin
        if (stall_left < stall) check32({name, "_stall_macl"}, mac_if.macl, pre_l);
        mac_if.ce = 1'b0;
        stall_left--;
      end else begin
        mac_if.ce = 1'b1;
      end
      if (hold_junk) begin
        mac_if.start = 1'b1; mac_if.op = MAC_OP_MULSW; mac_if.a = 32'h3; mac_if.b = 32'h3;
        mac_if.wr = 1'b1; mac_if.wsel = 1'b0; mac_if.wd = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    mac_if.ce = 1'b1; mac_if.start = 1'b0; mac_if.wr = 1'b0; mac_if.op = MAC_OP_NOP;
    if (cnt >= 20) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=busy_stuck required=idle", name);
    end
    got = sb_q.pop_front();
    check_int({got.name, "_busy"}, cnt, got.busy);
    check32({got.name, "_mach"}, mac_if.mach, got.h);
    check32({got.name, "_macl"}, mac_if.macl, got.l);
    mac_if.rsel = 1'b1; #1;
    check32({got.name, "_rd_h"}, mac_if.rd, got.h);
    mac_if.rsel = 1'b0; #1;
    check32({got.name, "_rd_l"}, mac_if.rd, got.l);
    $display("TXN %-10s mach=%08h macl=%08h busy=%0d", got.name, mac_if.mach, mac_if.macl, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name      op             sat   a             b             pre_h         pre_l         exp_h         exp_l        busy
    vecs.push_back('{"mulsw",   MAC_OP_MULSW,  1'b0, 32'h0000FFFE, 32'h00000003, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFA, 1});
    vecs.push_back('{"muluw",   MAC_OP_MULUW,  1'b0, 32'h0000FFFE, 32'h00000003, 32'h12345678, 32'h00000000, 32'h12345678, 32'h0002FFFA, 1});
    vecs.push_back('{"muluw_hi",MAC_OP_MULUW,  1'b0, 32'hABCD8000, 32'h12340002, 32'h0000000A, 32'h0000000B, 32'h0000000A, 32'h00010000, 1});
    vecs.push_back('{"mulsw_hi",MAC_OP_MULSW,  1'b0, 32'hABCD8000, 32'h12340002, 32'h0000000A, 32'h0000000B, 32'h0000000A, 32'hFFFF0000, 1});
    vecs.push_back('{"mull",    MAC_OP_MULL,   1'b0, 32'h12345678, 32'h00010001, 32'hAAAA5555, 32'h00000000, 32'hAAAA5555, 32'h68AC5678, 2});
    vecs.push_back('{"dmulsl",  MAC_OP_DMULSL, 1'b0, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 2});
    vecs.push_back('{"dmulul",  MAC_OP_DMULUL, 1'b0, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000, 2});
    vecs.push_back('{"dmulsl_m1",MAC_OP_DMULSL,1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11111111, 32'h22222222, 32'h00000000, 32'h00000001, 2});
    vecs.push_back('{"dmulul_m1",MAC_OP_DMULUL,1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11111111, 32'h22222222, 32'hFFFFFFFE, 32'h00000001, 2});
    vecs.push_back('{"macw_s1p",MAC_OP_MACW,   1'b1, 32'h00000010, 32'h00000010, 32'h00000000, 32'h7FFFFFF0, 32'h00000001, 32'h7FFFFFFF, 1});
    vecs.push_back('{"macw_s0", MAC_OP_MACW,   1'b0, 32'h00000010, 32'h00000010, 32'h00000000, 32'h7FFFFFF0, 32'h00000000, 32'h800000F0, 1});
    vecs.push_back('{"macw_s1n",MAC_OP_MACW,   1'b1, 32'h0000FFFF, 32'h00000100, 32'h12340000, 32'h80000010, 32'h12340001, 32'h80000000, 1});
    vecs.push_back('{"macw_s1ok",MAC_OP_MACW,  1'b1, 32'h0000FFFE, 32'h00000003, 32'hABCD0000, 32'h00000010, 32'hABCD0000, 32'h0000000A, 1});
    vecs.push_back('{"macw_neg",MAC_OP_MACW,   1'b0, 32'h0000FFFF, 32'h00000010, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF5, 1});
    vecs.push_back('{"macl_s0", MAC_OP_MACL,   1'b0, 32'h00000100, 32'h00000100, 32'h00007FFF, 32'hFFFFFF00, 32'h00008000, 32'h0000FF00, 2});
    vecs.push_back('{"macl_s1n",MAC_OP_MACL,   1'b1, 32'hFFFFFFFF, 32'h00000100, 32'hFFFF8000, 32'h00000010, 32'hFFFF8000, 32'h00000000, 2});
    vecs.push_back('{"macl_s1ok",MAC_OP_MACL,  1'b1, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 2});
    vecs.push_back('{"clrmac",  MAC_OP_CLRMAC, 1'b0, 32'h00000001, 32'h00000001, 32'h11111111, 32'h22222222, 32'h00000000, 32'h00000000, 0});
    vecs.push_back('{"nop",     MAC_OP_NOP,    1'b0, 32'h00000005, 32'h00000007, 32'h33333333, 32'h44444444, 32'h33333333, 32'h44444444, 0});
    vecs.push_back('{"op9",     4'd9,          1'b1, 32'h00000005, 32'h00000007, 32'h55555555, 32'h66666666, 32'h55555555, 32'h66666666, 0});

    mac_if.ce = 1'b1; mac_if.start = 1'b0; mac_if.op = MAC_OP_NOP; mac_if.sat = 1'b0;
    mac_if.a = '0; mac_if.b = '0; mac_if.wr = 1'b0; mac_if.wsel = 1'b0; mac_if.wd = '0;
    mac_if.rsel = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check32("reset_busy", {31'h0, mac_if.busy}, 32'h0);
    check32("reset_mach", mac_if.mach, 32'h0);
    check32("reset_macl", mac_if.macl, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      preload(vecs[i].pre_h, vecs[i].pre_l);
      run_op(vecs[i].name, vecs[i].op, vecs[i].sat, vecs[i].a, vecs[i].b,
             vecs[i].exp_h, vecs[i].exp_l, vecs[i].busy, 1'b0, 0);
    end

    // MAC.L saturating to the positive limit, then CLRMAC on the very next cycle.
    preload(32'h00007FFF, 32'hFFFFFF00);
    run_op("macl_s1p", MAC_OP_MACL, 1'b1, 32'h00000100, 32'h00000100,
           32'h00007FFF, 32'hFFFFFFFF, 2, 1'b0, 0);
    run_op("clr_after", MAC_OP_CLRMAC, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 0);

    // LDS write to MACL lands at the same edge as a MAC.W issue.
    preload(32'h00000000, 32'h00000077);
    mac_if.wr = 1'b1; mac_if.wsel = 1'b0; mac_if.wd = 32'h00000005;
    run_op("wr_start", MAC_OP_MACW, 1'b0, 32'h00000002, 32'h00000002,
           32'h00000000, 32'h00000009, 1, 1'b0, 0);

    // START and WR held while busy must be ignored.
    preload(32'h00000000, 32'h00000000);
    run_op("busy_hold", MAC_OP_DMULSL, 1'b0, 32'h80000000, 32'h00000002,
           32'hFFFFFFFF, 32'h00000000, 2, 1'b1, 0);

    // CE low for three cycles in MUL1 stretches BUSY without changing the result.
    preload(32'h12345678, 32'h00000000);
    run_op("ce_stall", MAC_OP_MULSW, 1'b0, 32'h0000FFFE, 32'h00000003,
           32'h12345678, 32'hFFFFFFFA, 4, 1'b0, 3);

    // Asynchronous reset in MUL2 of DMULU.L aborts the op.
    preload(32'h12345678, 32'h9ABCDEF0);
    mac_if.start = 1'b1; mac_if.op = MAC_OP_DMULUL; mac_if.a = 32'hFFFFFFFF; mac_if.b = 32'hFFFFFFFF;
    @(negedge clk);
    mac_if.start = 1'b0; mac_if.op = MAC_OP_NOP;
    @(negedge clk);
    check32("rst_pre_busy", {31'h0, mac_if.busy}, 32'h1);
    rst = 1'b1;
    #1;
    check32("rst_mid_busy", {31'h0, mac_if.busy}, 32'h0);
    check32("rst_mid_mach", mac_if.mach, 32'h0);
    check32("rst_mid_macl", mac_if.macl, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check32("rst_after_busy", {31'h0, mac_if.busy}, 32'h0);
    check32("rst_after_mach", mac_if.mach, 32'h0);
    check32("rst_after_macl", mac_if.macl, 32'h0);
    $display("TXN %-10s mach=%08h macl=%08h busy=%0d", "rst_mid", mac_if.mach, mac_if.macl, mac_if.busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sh2_mac_unit.md
Name: sh2_mac_unit

Overview:
Multiply/accumulate unit of the SH-2 core, sitting beside the EX stage and driven by the decoded MAC control field (select, read, write, 4-bit op).
- Owns MACH/MACL and executes MULS.W, MULU.W, MUL.L, DMULS.L, DMULU.L, MAC.W, MAC.L and CLRMAC.
- Serves LDS writes and STS reads of MACH/MACL.
- Runs multi-cycle on one shared 33x17 signed multiplier and raises BUSY so the pipeline stalls dependent accesses.

Parameters:
- RESET_MACH, 32'h00000000, MACH value after reset.
- RESET_MACL, 32'h00000000, MACL value after reset.

Ports:
- CLK  in  1  core clock
- RST  in  1  asynchronous, active-high reset
- CE  in  1  clock enable; state, registers and counters advance only when CE=1
- START  in  1  issue MAC op (sampled when CE=1 and BUSY=0)
- OP  in  4  MAC op code (MAC_OP_* constants)
- SAT  in  1  SR.S value at issue
- A  in  32  operand A (Rm, or memory data for MAC.x)
- B  in  32  operand B (Rn, or memory data for MAC.x)
- WR  in  1  LDS write strobe
- WSEL  in  1  write select: 0=MACL, 1=MACH
- WD  in  32  LDS write data
- RSEL  in  1  read select: 0=MACL, 1=MACH
- RD  out  32  combinational read of selected register (STS)
- MACH  out  32  MACH register
- MACL  out  32  MACL register
- BUSY  out  1  op in flight; pipeline must stall MAC access and new START

Behaviour:
- Reset (async, RST=1):
  - MACH=RESET_MACH, MACL=RESET_MACL, BUSY=0, state=IDLE.
  - Operand and partial-product latches cleared.
  - Reset mid-operation aborts the op; no partial write.
- FSM states: IDLE, MUL1, MUL2.
  - IDLE, START with a word op (MULS.W, MULU.W, MAC.W) -> MUL1; operands latched.
  - IDLE, START with a long op (MUL.L, DMULS.L, DMULU.L, MAC.L) -> MUL1.
  - MUL1, word op: product = ext(A[15:0]) * ext(B[15:0]). Result written at the MUL1 edge -> IDLE. BUSY high 1 cycle.
  - MUL1, long op: partial P = A * {0, B[15:0]}, stored -> MUL2.
  - MUL2: product = (A * ext(B[31:16]) << 16) + P. Written at the MUL2 edge -> IDLE. BUSY high 2 cycles.
  - ext is sign-extension for signed ops, zero-extension for unsigned ops. A is 33-bit-extended the same way.
- BUSY = (state != IDLE). Registered result is visible on MACH/MACL/RD the cycle after the final edge.
- CE=0 freezes state, latches and registers. RD stays combinational.
- Result rules:
  - MULS.W / MULU.W: MACL = 32-bit product; MACH unchanged.
  - MUL.L: MACL = product[31:0]; MACH unchanged.
  - DMULS.L / DMULU.L: {MACH,MACL} = 64-bit product.
  - MAC.W, SAT=0: {MACH,MACL} += sext64(product).
  - MAC.W, SAT=1: MACL = sat32(MACL + product), MACL taken as signed 32.
    - Overflow: MACL=7FFFFFFF (positive) or 80000000 (negative), and MACH[0] is set to 1.
    - No overflow: MACH unchanged.
  - MAC.L, SAT=0: {MACH,MACL} += product (64-bit wrap).
  - MAC.L, SAT=1: sum clamped to the 48-bit signed range 0xFFFF8000_00000000 .. 0x00007FFF_FFFFFFFF.
- CLRMAC: single cycle, BUSY stays 0; MACH=MACL=0 at the issuing edge.
- Unused OP codes: no-op, BUSY stays 0.
- START while BUSY=1 is ignored; the pipeline is required to hold.
- WR while BUSY=1 is ignored; the pipeline is required to stall.
- WR and START in the same cycle: the write lands at that edge, and the accumulate ops then use the written value.
- SAT is latched at issue; changes after issue have no effect.

Decomposition:
- SH2_PKG holds:
  - MAC_OP_* 4-bit constants: NOP=0, MULSW=1, MULUW=2, MULL=3, DMULSL=4, DMULUL=5, MACW=6, MACL=7, CLRMAC=8.
  - MAC FSM state enum.
  - MACW_SAT_MAX/MIN and MACL_SAT_MAX/MIN constants.
- Sub-module sh2_mac_mult: combinational 33x17 signed multiplier with a 50-bit result, reused in MUL1 and MUL2.

Test Plan:
- Reset: RST pulse mid-MUL2 of DMULU.L -> MACH=MACL=0, BUSY=0 immediately, no later write.
- MULS.W: A=0000FFFE, B=00000003 -> BUSY 1 cycle, MACL=FFFFFFFA, MACH unchanged (0x12345678 preloaded via LDS).
- DMULS.L: A=80000000, B=00000002 -> BUSY 2 cycles, MACH=FFFFFFFF, MACL=00000000. DMULU.L same operands -> MACH=00000001, MACL=00000000.
- MAC.W, SAT=1: MACL=7FFFFFF0, A=B=00000010 -> MACL=7FFFFFFF, MACH[0]=1. Same with SAT=0, MACH=0 -> MACH=0, MACL=800000F0.
- MAC.L, SAT=1: {MACH,MACL}=00007FFF_FFFFFF00, A=B=00000100 -> 00007FFF_FFFFFFFF. CLRMAC next cycle -> both 0, BUSY stays 0.
- Hazards:
  - WR MACL=5 with START MAC.W (SAT=0, MACH=0, A=B=00000002) same cycle -> MACL=9.
  - START while BUSY is ignored.
  - CE=0 for 3 cycles in MUL1 stretches BUSY by 3 with the result unchanged.
